// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI master arbiter: parameter defaults, FSM
// state encoding and the transfer-counter width helper.
package spi_arb_pkg;

  localparam int N_REQ_DEF       = 3;
  localparam int DATA_W_DEF      = 8;
  localparam int XFER_CYCLES_DEF = 8;

  // slaveSelect on the Master is fixed at two bits, which bounds N_REQ to 4.
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // The counter is loaded with cycles-1, so $clog2(cycles) bits suffice.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(XFER_CYCLES_DEF);

endpackage

// File: rtl/rr_priority.sv
// Combinational round-robin picker: the first set request at or above the
// pointer, wrapping modulo N_REQ. Usable by any shared-resource arbiter.
module rr_priority
  import spi_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             valid
);

  // Scan from the farthest offset down to the pointer so the nearest set
  // request is written last and wins, without needing an early loop exit.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment; otherwise a path leaving it untouched infers a latch.
    winner = '0;
    valid  = 1'b0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      if (req[(int'(ptr) + off) % N_REQ]) begin
        winner = SEL_W'((int'(ptr) + off) % N_REQ);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI Master among N_REQ requesters: round-robin grant, a timed
// fixed-length transfer, and a one-cycle acknowledge carrying the RX word.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int XFER_CYCLES = XFER_CYCLES_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          ack,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy,
  output logic                      start,
  output logic [SEL_W-1:0]          slaveSelect,
  output logic [DATA_W-1:0]         masterDataToSend,
  input  logic [DATA_W-1:0]         masterDataReceived
);

  localparam int              CNT_W    = cnt_width(XFER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XFER_CYCLES - 1);

  arb_state_t       state;
  arb_state_t       state_next;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] pick;
  logic             pick_valid;
  logic [CNT_W-1:0] cnt;
  logic             grant;
  logic             shift_last;

  rr_priority #(
    .N_REQ (N_REQ)
  ) u_rr (
    .req    (req),
    .ptr    (ptr),
    .winner (pick),
    .valid  (pick_valid)
  );

  assign grant      = (state == IDLE) && pick_valid;
  assign shift_last = (state == SHIFT) && (cnt == '0);

  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] w);
    return (w == SEL_W'(N_REQ - 1)) ? '0 : w + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every flop samples the pre-edge values regardless of process order.
      state <= state_next;
    end
  end

  // Next-state logic and the state-decoded outputs. Decoding start/busy/ack
  // straight from the state register makes them clear the moment reset hits.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    busy       = 1'b1;
    ack        = '0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (pick_valid) state_next = START;
      end
      START: begin
        start      = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        if (shift_last) state_next = DONE;
      end
      DONE: begin
        for (int i = 0; i < N_REQ; i++) begin
          ack[i] = (slaveSelect == SEL_W'(i));
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Grant registers, transfer counter and RX capture. slaveSelect doubles as
  // the registered winner index that steers ack in DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr              <= '0;
      slaveSelect      <= '0;
      masterDataToSend <= '0;
      cnt              <= '0;
      rsp_data         <= '0;
    end else begin
      if (grant) begin
        slaveSelect      <= pick;
        masterDataToSend <= req_data[pick*DATA_W +: DATA_W];
        ptr              <= next_ptr(pick);
      end
      if (state == START) begin
        cnt <= CNT_LOAD;
      end else if ((state == SHIFT) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (shift_last) begin
        rsp_data <= masterDataReceived;
      end
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level round-robin model.
module tb_spi_arbiter;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int XC = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   ack;
  logic [W-1:0]   rsp_data;
  logic           busy;
  logic           start;
  logic [1:0]     slaveSelect;
  logic [W-1:0]   masterDataToSend;
  logic [W-1:0]   masterDataReceived;

  int checks = 0;
  int errors = 0;
  int mptr   = 0;

  logic [W-1:0] pattern [N];

  // Master stand-in: latches MOSI on start and shows the addressed slave's
  // MISO word only in the final cycle of the transfer, garbage otherwise.
  logic [W-1:0] mosi_cap;
  logic [1:0]   sel_cap;
  int           remain;
  logic         active;

  always #5 clk = ~clk;

  spi_arbiter #(
    .N_REQ       (N),
    .DATA_W      (W),
    .XFER_CYCLES (XC)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .req                (req),
    .req_data           (req_data),
    .ack                (ack),
    .rsp_data           (rsp_data),
    .busy               (busy),
    .start              (start),
    .slaveSelect        (slaveSelect),
    .masterDataToSend   (masterDataToSend),
    .masterDataReceived (masterDataReceived)
  );

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mosi_cap <= '0;
      sel_cap  <= '0;
      remain   <= 0;
      active   <= 1'b0;
    end else if (start) begin
      mosi_cap <= masterDataToSend;
      sel_cap  <= slaveSelect;
      remain   <= XC - 1;
      active   <= 1'b1;
    end else if (active) begin
      if (remain == 0) active <= 1'b0;
      else             remain <= remain - 1;
    end
  end

  assign masterDataReceived = (active && remain == 0) ? pattern[sel_cap] : 8'hEE;

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Entered at the falling edge of an IDLE cycle with req already set; the
  // next rising edge is the sampling edge. Returns at the falling edge of the
  // IDLE cycle that follows the ack.
  task automatic do_xfer(input int exp, input logic [N-1:0] pulse_mask,
                         input logic [N-1:0] drop_mask, input logic [N-1:0] release_mask);
    logic [W-1:0] exp_tx;
    logic [W-1:0] exp_rx;
    logic [N-1:0] exp_ack;
    logic [1:0]   exp_sel;
    exp_tx  = req_data[exp*W +: W];
    exp_rx  = pattern[exp];
    exp_ack = N'(1) << exp;
    exp_sel = 2'(exp);
    mptr    = (exp + 1) % N;

    @(negedge clk);
    checks++;
    if ({start, busy, ack, slaveSelect, masterDataToSend} !== {1'b1, 1'b1, 3'b000, exp_sel, exp_tx}) begin
      errors++;
      $display("FAIL start_cycle: got start=%b busy=%b ack=%b sel=%0d tx=%h, expected start=1 busy=1 ack=000 sel=%0d tx=%h",
               start, busy, ack, slaveSelect, masterDataToSend, exp_sel, exp_tx);
    end

    for (int k = 1; k <= XC; k++) begin
      @(negedge clk);
      checks++;
      if ({start, busy, ack, slaveSelect, masterDataToSend} !== {1'b0, 1'b1, 3'b000, exp_sel, exp_tx}) begin
        errors++;
        $display("FAIL shift_cycle_%0d: got start=%b busy=%b ack=%b sel=%0d tx=%h, expected start=0 busy=1 ack=000 sel=%0d tx=%h",
                 k, start, busy, ack, slaveSelect, masterDataToSend, exp_sel, exp_tx);
      end
      if (k == 2) req = req | pulse_mask;
      if (k == 3) req = req & ~drop_mask;
      if (k == 4) req = req & ~pulse_mask;
    end

    @(negedge clk);
    checks++;
    if ({ack, rsp_data, busy, start, slaveSelect} !== {exp_ack, exp_rx, 1'b1, 1'b0, exp_sel}) begin
      errors++;
      $display("FAIL ack_cycle: got ack=%b rsp=%h busy=%b start=%b sel=%0d, expected ack=%b rsp=%h busy=1 start=0 sel=%0d",
               ack, rsp_data, busy, start, slaveSelect, exp_ack, exp_rx, exp_sel);
    end
    checks++;
    if (mosi_cap !== exp_tx) begin
      errors++;
      $display("FAIL mosi_word: got %h expected %h", mosi_cap, exp_tx);
    end
    req = req & ~release_mask;

    @(negedge clk);
    checks++;
    if ({busy, ack, start, rsp_data, slaveSelect} !== {1'b0, 3'b000, 1'b0, exp_rx, exp_sel}) begin
      errors++;
      $display("FAIL idle_after_ack: got busy=%b ack=%b start=%b rsp=%h sel=%0d, expected busy=0 ack=000 start=0 rsp=%h sel=%0d",
               busy, ack, start, rsp_data, slaveSelect, exp_rx, exp_sel);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({ack, rsp_data, busy, start, slaveSelect, masterDataToSend} !== '0) begin
      errors++;
      $display("FAIL %s: got ack=%b rsp=%h busy=%b start=%b sel=%0d tx=%h, expected all zero",
               name, ack, rsp_data, busy, start, slaveSelect, masterDataToSend);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    req   = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    reset = 1'b1;
    mptr  = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    req_data = '0;
    apply_reset();
  endtask

  task automatic test_single();
    req_data[0*W +: W] = 8'h2B;
    req = 3'b001;
    do_xfer(0, 3'b000, 3'b000, 3'b001);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    req_data = {8'hC4, 8'h7A, 8'h2B};
    req = 3'b111;
    do_xfer(0, 3'b000, 3'b000, 3'b000);
    do_xfer(1, 3'b000, 3'b000, 3'b000);
    do_xfer(2, 3'b000, 3'b000, 3'b000);
    do_xfer(0, 3'b000, 3'b000, 3'b111);
  endtask

  task automatic test_rotation();
    req = 3'b010;
    do_xfer(1, 3'b000, 3'b000, 3'b010);
    req = 3'b011;
    do_xfer(0, 3'b000, 3'b000, 3'b001);
    do_xfer(1, 3'b000, 3'b000, 3'b010);
  endtask

  task automatic test_withdrawal();
    req_data[0*W +: W] = 8'h5A;
    req = 3'b001;
    do_xfer(0, 3'b100, 3'b001, 3'b000);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      checks++;
      if ({busy, ack} !== 4'b0000) begin
        errors++;
        $display("FAIL withdrawn_idle_%0d: got busy=%b ack=%b expected busy=0 ack=000", k, busy, ack);
      end
    end
  endtask

  task automatic test_reset_mid();
    req_data[0*W +: W] = 8'h3C;
    req = 3'b001;
    @(negedge clk);
    checks++;
    if (start !== 1'b1) begin
      errors++;
      $display("FAIL mid_start: got %b expected 1", start);
    end
    repeat (5) @(negedge clk);
    reset = 1'b0;
    req   = '0;
    #1;
    check_all_zero("reset_mid_shift");
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check_all_zero("reset_hold");
    end
    reset = 1'b1;
    mptr  = 0;
    req_data[2*W +: W] = 8'hA7;
    req = 3'b100;
    do_xfer(2, 3'b000, 3'b000, 3'b100);
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    int           exp;
    for (int i = 0; i < N; i++) pattern[i] = W'($urandom);
    for (int it = 0; it < 40; it++) begin
      r        = N'($urandom_range(0, 7));
      req_data = (N*W)'($urandom);
      req      = r;
      if (r == '0) begin
        @(negedge clk);
        checks++;
        if ({busy, ack, start} !== 5'b00000) begin
          errors++;
          $display("FAIL random_idle_%0d: got busy=%b ack=%b start=%b expected all zero", it, busy, ack, start);
        end
      end else begin
        exp = rr_pick(r, mptr);
        do_xfer(exp, 3'b000, N'($urandom_range(0, 7)), 3'b111);
      end
    end
  endtask

  initial begin
    pattern[0] = 8'h09;
    pattern[1] = 8'h25;
    pattern[2] = 8'h5C;
    reset = 1'b0;
    req   = '0;
    req_data = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_rotation();
    test_withdrawal();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
